qf_sync_req_arb: RTL

- Destination-domain receiver and arbiter for two-phase (toggle) requests from NUM_REQ requesters in a foreign clock domain.
- Each request carries bundled data that the source holds stable until it sees the matching ack toggle.
- The block synchronizes each request toggle through the team's 2-flop synchronizer qf_dff, arbitrates pending requests round-robin, and forwards the winner's data on a single valid/ready output.
- It returns a per-requester ack toggle. It sits between the FCB-side configuration sources and the dest_clk register-write path.

---
 rtl/qf_sync_req_arb_pkg.sv | 36 +++
 rtl/qf_sync_req_arb_if.sv | 29 ++
 rtl/qf_dff.sv | 27 ++
 rtl/qf_rr_arb.sv | 35 +++
 rtl/qf_sync_req_arb.sv | 99 +++++++++
 5 files changed

// File: rtl/qf_sync_req_arb_pkg.sv
// Shared constants and helpers for the toggle-request synchronizer/arbiter.
package qf_sync_arb_pkg;

    // Depth of the request-toggle synchronizer (qf_dff is a 2-flop chain).
    localparam int SYNC_LAT = 2;

    // Widest requester vector the round-robin helper handles.
    localparam int RR_MAX = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // Round-robin pick: first set bit of pend scanning upward from last+1,
    // wrapping modulo n. The found flag is clear when nothing is pending.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] pend,
                                         input logic [3:0]        last,
                                         input int                n);
        rr_pick_t r;
        int       j;
        r.found = 1'b0;
        r.idx   = 4'd0;
        for (int k = 1; k <= RR_MAX; k++) begin
            if (k <= n) begin
                j = (int'(last) + k) % n;
                if (!r.found && pend[j[3:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[3:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/qf_sync_req_arb_if.sv
// Request/ack and output handshake bundle of qf_sync_req_arb.
// master: the arbiter side; slave: the requesters plus downstream consumer.
interface qf_sync_req_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            src_req_tgl;
    logic [NUM_REQ*DATA_WIDTH-1:0] src_data;
    logic                          arb_en;
    logic [NUM_REQ-1:0]            dest_ack_tgl;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [ID_W-1:0]               out_id;
    logic [NUM_REQ-1:0]            pending;

    modport master (
        input  src_req_tgl, src_data, arb_en, out_ready,
        output dest_ack_tgl, out_valid, out_data, out_id, pending
    );

    modport slave (
        output src_req_tgl, src_data, arb_en, out_ready,
        input  dest_ack_tgl, out_valid, out_data, out_id, pending
    );

endinterface

// File: rtl/qf_dff.sv
// Two-flop synchronizer for a vector of independent level/toggle signals.
module qf_dff #(
    parameter int PAR_DFF_WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PAR_DFF_WIDTH-1:0] d,
    output logic [PAR_DFF_WIDTH-1:0] q
);

    logic [PAR_DFF_WIDTH-1:0] meta_reg;
    logic [PAR_DFF_WIDTH-1:0] sync_reg;

    // Metastability-settling chain; first stage may go metastable, second is clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/qf_rr_arb.sv
// Round-robin picker over the pending vector plus the last-grant pointer.
module qf_rr_arb
    import qf_sync_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               dest_clk,
    input  logic               dest_rst_n,
    input  logic [NUM_REQ-1:0] pend,
    input  logic               grant_en,
    output logic               grant,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W-1:0] last_grant_reg;
    rr_pick_t        pick;

    // Winner search starts just above the previous winner.
    always_comb begin
        pick     = rr_pick(RR_MAX'(pend), 4'(last_grant_reg), NUM_REQ);
        grant    = grant_en && pick.found;
        grant_id = pick.idx[ID_W-1:0];
    end

    // Pointer resets to the top index so requester 0 has first priority.
    always_ff @(posedge dest_clk or negedge dest_rst_n) begin
        if (!dest_rst_n) begin
            last_grant_reg <= ID_W'(NUM_REQ - 1);
        end else if (grant) begin
            last_grant_reg <= grant_id;
        end
    end

endmodule

// File: rtl/qf_sync_req_arb.sv
// Destination-side receiver for two-phase requests: synchronizes the request
// toggles, arbitrates round-robin and forwards one word at a time on a
// valid/ready output, answering each served request with an ack toggle.
// A requester that toggles twice without waiting for its ack cancels its own
// request through the XOR; that is a source protocol error and is not flagged.
module qf_sync_req_arb
    import qf_sync_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic               dest_clk,
    input  logic               dest_rst_n,
    qf_sync_req_arb_if.master  bus
);

    logic [NUM_REQ-1:0]    req_s;
    logic [NUM_REQ-1:0]    pend_c;
    logic [NUM_REQ-1:0]    ack_reg;
    logic [NUM_REQ-1:0]    pending_reg;
    logic [NUM_REQ-1:0]    grant_onehot;
    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [ID_W-1:0]       out_id_reg;
    logic                  slot_free;
    logic                  grant_en;
    logic                  grant;
    logic [ID_W-1:0]       grant_id;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    qf_dff #(
        .PAR_DFF_WIDTH(NUM_REQ)
    ) u_req_sync (
        .clk  (dest_clk),
        .rst_n(dest_rst_n),
        .d    (bus.src_req_tgl),
        .q    (req_s)
    );

    // A request is outstanding while its synchronized toggle differs from our ack.
    always_comb begin
        pend_c    = req_s ^ ack_reg;
        slot_free = !out_valid_reg || bus.out_ready;
        grant_en  = bus.arb_en && slot_free;
    end

    qf_rr_arb #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arb (
        .dest_clk  (dest_clk),
        .dest_rst_n(dest_rst_n),
        .pend      (pend_c),
        .grant_en  (grant_en),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    // Per-requester data slices and one-hot ack-toggle enables.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_arr[gi]     = bus.src_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign grant_onehot[gi] = grant && (grant_id == ID_W'(gi));
        end
    endgenerate

    // Ack toggles for the winner; the toggle clears its pend_c bit next cycle.
    always_ff @(posedge dest_clk or negedge dest_rst_n) begin
        if (!dest_rst_n) begin
            ack_reg     <= '0;
            pending_reg <= '0;
        end else begin
            ack_reg     <= ack_reg ^ grant_onehot;
            pending_reg <= pend_c;
        end
    end

    // Output holding register; data/id only move when the slot is free.
    always_ff @(posedge dest_clk or negedge dest_rst_n) begin
        if (!dest_rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_id_reg    <= '0;
        end else if (grant) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= data_arr[grant_id];
            out_id_reg    <= grant_id;
        end else if (out_valid_reg && bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.dest_ack_tgl = ack_reg;
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_data     = out_data_reg;
    assign bus.out_id       = out_id_reg;
    assign bus.pending      = pending_reg;

endmodule
